// File: rtl/instr_cache_pkg.sv
// rtl/instr_cache_pkg.sv - shared constants and types for the instruction cache
package instr_cache_pkg;

  // Default log2 of the entry count; entries are keyed per halfword address.
  localparam int IC_INDEX_WIDTH_DEF = 6;

  // Register-file index width, shared with the rest of the core.
  localparam int REG_NUM_WIDTH = 5;

  // Miss FSM encodings.
  localparam logic [1:0] IC_IDLE  = 2'd0;
  localparam logic [1:0] IC_MISS  = 2'd1;
  localparam logic [1:0] IC_ABORT = 2'd2;

  typedef logic [1:0] ic_state_t;

endpackage

// File: rtl/instr_cache_icache_array.sv
// rtl/instr_cache_icache_array.sv - valid/tag/data storage with one comb read and one sync write port
module icache_array
  import instr_cache_pkg::*;
#(
  parameter int IC_INDEX_WIDTH = IC_INDEX_WIDTH_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [IC_INDEX_WIDTH-1:0]   rd_index,
  output logic                        rd_valid,
  output logic [30-IC_INDEX_WIDTH:0]  rd_tag,
  output logic [31:0]                 rd_data,
  input  logic                        wr_en,
  input  logic [IC_INDEX_WIDTH-1:0]   wr_index,
  input  logic [30-IC_INDEX_WIDTH:0]  wr_tag,
  input  logic [31:0]                 wr_data
);

  localparam int ENTRIES = 1 << IC_INDEX_WIDTH;

  logic [ENTRIES-1:0]          valid_q;
  logic [ENTRIES-1:0]          valid_d;
  logic [30-IC_INDEX_WIDTH:0]  tag_q  [ENTRIES];
  logic [31:0]                 data_q [ENTRIES];

  // Next valid vector: a fill marks its entry valid, nothing else clears except reset.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_index] = 1'b1;
  end

  // Valid bits are the only reset state; tag/data are don't-care while invalid.
  always_ff @(posedge clk_in) begin
    if (rst_in) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag and data storage, written on a fill.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped halfword-keyed instruction cache with miss FSM
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int IC_INDEX_WIDTH = IC_INDEX_WIDTH_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        need_flush_in,
  input  logic        fetch_enable_in,
  input  logic [31:0] pc_in,
  output logic        ic_hit,
  output logic        ic_miss_ready,
  output logic [31:0] ic_instr,
  output logic        ic2mc_req,
  output logic [31:0] ic2mc_addr,
  input  logic        mc2ic_done,
  input  logic [31:0] mc2ic_data
);

  ic_state_t   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] miss_data_q, miss_data_d;
  logic        miss_ready_q, miss_ready_d;

  logic                        rd_valid;
  logic [30-IC_INDEX_WIDTH:0]  rd_tag;
  logic [31:0]                 rd_data;
  logic                        fill_en;
  logic                        lookup_match;
  logic                        unused_pc_bit0;

  // Bit 0 of the PC is always zero for a halfword-aligned fetch.
  assign unused_pc_bit0 = pc_in[0];

  icache_array #(
    .IC_INDEX_WIDTH(IC_INDEX_WIDTH)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (pc_in[IC_INDEX_WIDTH:1]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_en),
    .wr_index (addr_q[IC_INDEX_WIDTH:1]),
    .wr_tag   (addr_q[31:IC_INDEX_WIDTH+1]),
    .wr_data  (mc2ic_data)
  );

  assign lookup_match = rd_valid && (rd_tag == pc_in[31:IC_INDEX_WIDTH+1]);
  assign ic_hit = rdy_in && fetch_enable_in && !need_flush_in &&
                  (state_q == IC_IDLE) && lookup_match;
  assign ic_instr      = ic_hit ? rd_data : miss_data_q;
  assign ic_miss_ready = miss_ready_q;
  assign ic2mc_req     = (state_q == IC_MISS) || (state_q == IC_ABORT);
  assign ic2mc_addr    = addr_q;

  // The entry is filled whenever an outstanding read completes, wanted or not.
  assign fill_en = rdy_in && mc2ic_done && (state_q != IC_IDLE);

  // Miss FSM: launch on lookup miss, demote to ABORT on flush, fill on done.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    miss_data_d  = miss_data_q;
    miss_ready_d = 1'b0;
    if (!rdy_in) begin
      miss_ready_d = miss_ready_q;
    end else begin
      case (state_q)
        IC_IDLE: begin
          if (fetch_enable_in && !need_flush_in && !lookup_match) begin
            state_d = IC_MISS;
            addr_d  = pc_in;
          end
        end
        IC_MISS: begin
          if (mc2ic_done) begin
            state_d = IC_IDLE;
            if (!need_flush_in) begin
              miss_data_d  = mc2ic_data;
              miss_ready_d = 1'b1;
            end
          end else if (need_flush_in) begin
            state_d = IC_ABORT;
          end
        end
        IC_ABORT: begin
          if (mc2ic_done) state_d = IC_IDLE;
        end
        default: state_d = IC_IDLE;
      endcase
    end
  end

  // FSM, request address, miss register and ready pulse registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IC_IDLE;
      addr_q       <= '0;
      miss_data_q  <= '0;
      miss_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      miss_data_q  <= miss_data_d;
      miss_ready_q <= miss_ready_d;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - self-checking bench for instr_cache with a behavioural cache model
module tb_instr_cache;

  localparam int IW = 6;
  localparam int N  = 1 << IW;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        need_flush_in;
  logic        fetch_enable_in;
  logic [31:0] pc_in;
  logic        ic_hit;
  logic        ic_miss_ready;
  logic [31:0] ic_instr;
  logic        ic2mc_req;
  logic [31:0] ic2mc_addr;
  logic        mc2ic_done;
  logic [31:0] mc2ic_data;

  int checks = 0;
  int errors = 0;

  // Model: each slot remembers the full PC it holds and the 32-bit window.
  bit          m_valid [N];
  logic [31:0] m_pc    [N];
  logic [31:0] m_data  [N];

  instr_cache #(.IC_INDEX_WIDTH(IW)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .need_flush_in   (need_flush_in),
    .fetch_enable_in (fetch_enable_in),
    .pc_in           (pc_in),
    .ic_hit          (ic_hit),
    .ic_miss_ready   (ic_miss_ready),
    .ic_instr        (ic_instr),
    .ic2mc_req       (ic2mc_req),
    .ic2mc_addr      (ic2mc_addr),
    .mc2ic_done      (mc2ic_done),
    .mc2ic_data      (mc2ic_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 1) % N);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_pc[slot(pc)] == pc);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch: checks the hit path, or the full miss handshake with optional
  // flush mid-miss, flush in the done cycle, and rdy_in held low for a while.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                          input int delay, input int flush_cyc,
                          input bit flush_done, input int rdy_low);
    bit exp_hit;
    bit aborted;
    bit exp_pulse;
    exp_hit = model_hit(pc);
    fetch_enable_in = 1'b1;
    pc_in = pc;
    @(negedge clk);
    checks++;
    if (ic_hit !== exp_hit) begin
      errors++;
      $display("FAIL lookup_hit pc=%h got=%b exp=%b", pc, ic_hit, exp_hit);
    end
    if (exp_hit) begin
      checks++;
      if (ic_instr !== m_data[slot(pc)] || ic2mc_req !== 1'b0) begin
        errors++;
        $display("FAIL hit_data pc=%h got=%h req=%b exp=%h req=0", pc, ic_instr, ic2mc_req, m_data[slot(pc)]);
      end
      step();
      fetch_enable_in = 1'b0;
      return;
    end
    step();
    aborted = 1'b0;
    for (int i = 0; i < delay; i++) begin
      rdy_in = (i < rdy_low) ? 1'b0 : 1'b1;
      need_flush_in = (i == flush_cyc);
      @(negedge clk);
      checks++;
      if (ic2mc_req !== 1'b1 || ic2mc_addr !== pc || ic_hit !== 1'b0 || ic_miss_ready !== 1'b0) begin
        errors++;
        $display("FAIL miss_wait pc=%h cyc=%0d got req=%b addr=%h hit=%b rdy=%b exp req=1 addr=%h hit=0 rdy=0",
                 pc, i, ic2mc_req, ic2mc_addr, ic_hit, ic_miss_ready, pc);
      end
      step();
      if (need_flush_in && rdy_in) aborted = 1'b1;
    end
    rdy_in = 1'b1;
    need_flush_in = flush_done;
    mc2ic_done = 1'b1;
    mc2ic_data = data;
    @(negedge clk);
    checks++;
    if (ic2mc_req !== 1'b1) begin
      errors++;
      $display("FAIL req_in_done pc=%h got=%b exp=1", pc, ic2mc_req);
    end
    step();
    mc2ic_done = 1'b0;
    mc2ic_data = $urandom;
    need_flush_in = 1'b0;
    fetch_enable_in = 1'b0;
    m_valid[slot(pc)] = 1'b1;
    m_pc[slot(pc)]    = pc;
    m_data[slot(pc)]  = data;
    exp_pulse = !(aborted || flush_done);
    @(negedge clk);
    checks++;
    if (ic_miss_ready !== exp_pulse || ic2mc_req !== 1'b0) begin
      errors++;
      $display("FAIL miss_pulse pc=%h got rdy=%b req=%b exp rdy=%b req=0", pc, ic_miss_ready, ic2mc_req, exp_pulse);
    end
    if (exp_pulse) begin
      checks++;
      if (ic_instr !== data) begin
        errors++;
        $display("FAIL miss_data pc=%h got=%h exp=%h", pc, ic_instr, data);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (ic_miss_ready !== 1'b0) begin
      errors++;
      $display("FAIL pulse_fall pc=%h got=%b exp=0", pc, ic_miss_ready);
    end
    step();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    need_flush_in = 1'b0;
    fetch_enable_in = 1'b0;
    pc_in = 32'h0;
    mc2ic_done = 1'b0;
    mc2ic_data = 32'h0;
    model_clear();
    step();
    step();
    rst_in = 1'b0;
    fetch_enable_in = 1'b1;
    @(negedge clk);
    checks++;
    if (ic_hit !== 1'b0 || ic_miss_ready !== 1'b0 || ic2mc_req !== 1'b0 ||
        ic2mc_addr !== 32'h0 || ic_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got hit=%b rdy=%b req=%b addr=%h instr=%h exp all 0",
               ic_hit, ic_miss_ready, ic2mc_req, ic2mc_addr, ic_instr);
    end
    rst_in = 1'b1;
    fetch_enable_in = 1'b0;
    step();
    rst_in = 1'b0;
  endtask

  task automatic test_cold_miss_and_hit();
    do_fetch(32'h0000_0000, 32'h0000_0513, 5, -1, 1'b0, 0);
    do_fetch(32'h0000_0000, 32'hDEAD_BEEF, 5, -1, 1'b0, 0);
  endtask

  task automatic test_misaligned();
    do_fetch(32'h0000_0102, 32'h4505_4501, 3, -1, 1'b0, 0);
    do_fetch(32'h0000_0102, 32'h0, 0, -1, 1'b0, 0);
    do_fetch(32'h0000_0100, 32'h1111_2222, 2, -1, 1'b0, 0);
    do_fetch(32'h0000_0102, 32'h0, 0, -1, 1'b0, 0);
  endtask

  task automatic test_flush_mid_miss();
    do_fetch(32'h0000_0040, 32'h1234_5678, 5, 2, 1'b0, 0);
    do_fetch(32'h0000_0040, 32'h0, 0, -1, 1'b0, 0);
    do_fetch(32'h0000_0044, 32'h0BAD_F00D, 2, -1, 1'b1, 0);
    do_fetch(32'h0000_0044, 32'h0, 0, -1, 1'b0, 0);
  endtask

  task automatic test_conflict();
    do_fetch(32'h0000_0000, 32'hA0A0_A0A0, 1, -1, 1'b0, 0);
    do_fetch(32'h0000_0080, 32'hB0B0_B0B0, 1, -1, 1'b0, 0);
    do_fetch(32'h0000_0000, 32'hC0C0_C0C0, 1, -1, 1'b0, 0);
    do_fetch(32'h0000_0080, 32'h0, 0, -1, 1'b0, 0);
    do_fetch(32'h0000_0080, 32'h0, 0, -1, 1'b0, 0);
  endtask

  task automatic test_rdy_low();
    do_fetch(32'h0000_0200, 32'h7777_1234, 6, -1, 1'b0, 4);
    rdy_in = 1'b0;
    fetch_enable_in = 1'b1;
    pc_in = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if (ic_hit !== 1'b0) begin
      errors++;
      $display("FAIL rdy_low_hit got=%b exp=0", ic_hit);
    end
    step();
    rdy_in = 1'b1;
    fetch_enable_in = 1'b0;
    do_fetch(32'h0000_0200, 32'h0, 0, -1, 1'b0, 0);
  endtask

  task automatic test_reset_mid_miss();
    fetch_enable_in = 1'b1;
    pc_in = 32'h0000_0300;
    step();
    @(negedge clk);
    checks++;
    if (ic2mc_req !== 1'b1 || ic2mc_addr !== 32'h0000_0300) begin
      errors++;
      $display("FAIL rst_mid_req got req=%b addr=%h exp req=1 addr=00000300", ic2mc_req, ic2mc_addr);
    end
    rst_in = 1'b1;
    fetch_enable_in = 1'b0;
    step();
    rst_in = 1'b0;
    model_clear();
    mc2ic_done = 1'b1;
    mc2ic_data = 32'h5555_AAAA;
    @(negedge clk);
    checks++;
    if (ic2mc_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop_req got=%b exp=0", ic2mc_req);
    end
    step();
    mc2ic_done = 1'b0;
    @(negedge clk);
    checks++;
    if (ic_miss_ready !== 1'b0 || ic2mc_req !== 1'b0) begin
      errors++;
      $display("FAIL stale_done got rdy=%b req=%b exp 0 0", ic_miss_ready, ic2mc_req);
    end
    do_fetch(32'h0000_0300, 32'h3030_3030, 1, -1, 1'b0, 0);
    do_fetch(32'h0000_0000, 32'h0000_0513, 1, -1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      logic [31:0] pc;
      int d;
      int fc;
      pc = ($urandom_range(0, 3) * 32'h80) + ($urandom_range(0, 5) * 32'h2) + 32'h1000;
      d  = $urandom_range(0, 4);
      fc = ($urandom_range(0, 3) == 0 && d > 0) ? $urandom_range(0, d - 1) : -1;
      do_fetch(pc, $urandom, d, fc, ($urandom_range(0, 7) == 0), 0);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss_and_hit();
    test_misaligned();
    test_flush_mid_miss();
    test_conflict();
    test_rdy_low();
    test_reset_mid_miss();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
